// File: rtl/countdown_timer_ctrl.sv
// Programmable countdown timer controller: sequences an Nbits down-counter through
// one-shot / periodic runs with pause, abort, expiry pulse and a saturating period count.
module countdown_timer_ctrl #(
    parameter int Nbits = 4,
    parameter int PW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             tick_ena,
    input  logic             mode_periodic,
    input  logic [Nbits-1:0] load_val,
    input  logic             ack,
    output logic [Nbits-1:0] count,
    output logic             busy,
    output logic             expired,
    output logic             zero_err,
    output logic [PW-1:0]    periods,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [Nbits-1:0] count_nxt;
    logic [Nbits-1:0] reload, reload_nxt;
    logic             mode, mode_nxt;
    logic [PW-1:0]    periods_nxt;
    logic             expired_nxt;
    logic             zero_err_nxt;
    logic             busy_nxt;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_nxt    = state;
        count_nxt    = count;
        reload_nxt   = reload;
        mode_nxt     = mode;
        periods_nxt  = periods;
        expired_nxt  = 1'b0;
        zero_err_nxt = 1'b0;

        case (state)
            IDLE, DONE: begin
                // A start outranks ack in DONE, even when it is rejected for a zero load.
                if (start) begin
                    if (load_val == '0) begin
                        zero_err_nxt = 1'b1;
                    end else begin
                        count_nxt   = load_val;
                        reload_nxt  = load_val;
                        mode_nxt    = mode_periodic;
                        periods_nxt = '0;
                        state_nxt   = RUN;
                    end
                end else if (state == DONE && ack) begin
                    state_nxt = IDLE;
                end
            end

            RUN: begin
                if (stop) begin
                    count_nxt = '0;
                    state_nxt = IDLE;
                end else if (pause) begin
                    state_nxt = PAUSED;
                end else if (tick_ena) begin
                    if (count > 1) begin
                        count_nxt = count - 1'b1;
                    end else begin
                        // Zero is only ever reached here, so the counter never wraps.
                        expired_nxt = 1'b1;
                        if (periods != '1)
                            periods_nxt = periods + 1'b1;
                        if (mode) begin
                            count_nxt = reload;
                        end else begin
                            count_nxt = '0;
                            state_nxt = DONE;
                        end
                    end
                end
            end

            PAUSED: begin
                if (stop) begin
                    count_nxt = '0;
                    state_nxt = IDLE;
                end else if (!pause) begin
                    state_nxt = RUN;
                end
            end

            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt == RUN) || (state_nxt == PAUSED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            count    <= '0;
            reload   <= '0;
            mode     <= 1'b0;
            periods  <= '0;
            expired  <= 1'b0;
            zero_err <= 1'b0;
            busy     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
            state    <= state_nxt;
            count    <= count_nxt;
            reload   <= reload_nxt;
            mode     <= mode_nxt;
            periods  <= periods_nxt;
            expired  <= expired_nxt;
            zero_err <= zero_err_nxt;
            busy     <= busy_nxt;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Self-checking bench for countdown_timer_ctrl: directed scenarios followed by
// randomized control traffic, all compared against an event-level timer model.
module tb_countdown_timer_ctrl;

    localparam int NB = 4;
    localparam int PW = 4;
    localparam int PMAX = (1 << PW) - 1;

    logic          clk;
    logic          rst;
    logic          start, stop, pause, tick_ena, mode_periodic, ack;
    logic [NB-1:0] load_val;
    logic [NB-1:0] count;
    logic          busy, expired, zero_err;
    logic [PW-1:0] periods;
    logic [1:0]    state_o;

    countdown_timer_ctrl #(.Nbits(NB), .PW(PW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .tick_ena(tick_ena), .mode_periodic(mode_periodic), .load_val(load_val),
        .ack(ack), .count(count), .busy(busy), .expired(expired),
        .zero_err(zero_err), .periods(periods), .state_o(state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: timer phase as 0=idle 1=running 2=paused 3=done.
    int m_state, m_count, m_reload, m_periods;
    bit m_periodic, m_exp, m_zerr;

    function automatic void model_reset();
        m_state = 0; m_count = 0; m_reload = 0; m_periods = 0;
        m_periodic = 0; m_exp = 0; m_zerr = 0;
    endfunction

    function automatic void model_step();
        bit waiting;
        waiting = (m_state == 0) || (m_state == 3);
        m_exp  = 0;
        m_zerr = 0;
        if (waiting && start) begin
            if (load_val == 0) begin
                m_zerr = 1;
            end else begin
                m_count = load_val; m_reload = load_val;
                m_periodic = mode_periodic; m_periods = 0; m_state = 1;
            end
        end else if (m_state == 3 && ack) begin
            m_state = 0;
        end else if (!waiting && stop) begin
            m_count = 0; m_state = 0;
        end else if (m_state == 2) begin
            if (!pause) m_state = 1;
        end else if (m_state == 1 && pause) begin
            m_state = 2;
        end else if (m_state == 1 && tick_ena) begin
            m_count = m_count - 1;
            if (m_count == 0) begin
                m_exp = 1;
                m_periods = (m_periods + 1 > PMAX) ? PMAX : m_periods + 1;
                if (m_periodic) m_count = m_reload;
                else m_state = 3;
            end
        end
    endfunction

    task automatic compare_all();
        check("count", count, m_count);
        check("state", state_o, m_state);
        check("busy", busy, (m_state == 1 || m_state == 2) ? 1 : 0);
        check("expired", expired, m_exp);
        check("zero_err", zero_err, m_zerr);
        check("periods", periods, m_periods);
    endtask

    // One clock: DUT and model both see the inputs held across the edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic quiet();
        start = 0; stop = 0; pause = 0; tick_ena = 0; ack = 0;
        mode_periodic = 0; load_val = '0;
    endtask

    task automatic do_start(input int val, input bit per);
        start = 1; load_val = NB'(val); mode_periodic = per;
        cycle();
        start = 0;
    endtask

    initial begin
        rst = 0;
        quiet();
        model_reset();
        #3;
        compare_all();
        #9 rst = 1;

        // One-shot 3 -> 2,1,0 then DONE, ack back to idle.
        do_start(3, 0);
        tick_ena = 1;
        repeat (3) cycle();
        check("oneshot_expired", expired, 1);
        check("oneshot_done", state_o, 3);
        check("oneshot_periods", periods, 1);
        tick_ena = 0; ack = 1;
        cycle();
        ack = 0;
        check("oneshot_ack_idle", state_o, 0);

        // Periodic reload 2 for 8 ticks.
        do_start(2, 1);
        tick_ena = 1;
        repeat (8) cycle();
        check("periodic_periods", periods, 4);
        check("periodic_run", state_o, 1);
        tick_ena = 0; stop = 1;
        cycle();
        stop = 0;

        // Pause at 3 for 4 cycles, then resume to expiry.
        do_start(5, 0);
        tick_ena = 1;
        repeat (2) cycle();
        pause = 1;
        repeat (4) cycle();
        check("pause_hold", count, 3);
        check("pause_state", state_o, 2);
        pause = 0;
        repeat (4) cycle();
        check("pause_done_exp", expired, 1);
        tick_ena = 0; ack = 1;
        cycle();
        ack = 0;

        // stop beats pause and tick.
        do_start(6, 0);
        tick_ena = 1;
        repeat (2) cycle();
        check("prio_pre", count, 4);
        stop = 1; pause = 1;
        cycle();
        check("prio_count", count, 0);
        check("prio_state", state_o, 0);
        check("prio_noexp", expired, 0);
        quiet();

        // Zero load rejected.
        start = 1; load_val = '0;
        cycle();
        start = 0;
        check("zero_err", zero_err, 1);
        check("zero_idle", state_o, 0);
        cycle();
        check("zero_pulse_once", zero_err, 0);

        // Period counter saturation with reload 1.
        do_start(1, 1);
        tick_ena = 1;
        repeat (20) cycle();
        check("sat_periods", periods, PMAX);
        check("sat_expired", expired, 1);

        // Asynchronous reset between edges, mid-run.
        #2 rst = 0;
        model_reset();
        #1;
        check("arst_count", count, 0);
        check("arst_state", state_o, 0);
        check("arst_busy", busy, 0);
        #2 rst = 1;
        repeat (3) cycle();
        check("arst_stays_idle", state_o, 0);
        quiet();

        // Randomized control traffic.
        for (int i = 0; i < 3000; i++) begin
            start         = ($urandom_range(0, 7) == 0);
            stop          = ($urandom_range(0, 15) == 0);
            pause         = ($urandom_range(0, 3) == 0);
            tick_ena      = ($urandom_range(0, 1) == 1);
            ack           = ($urandom_range(0, 3) == 0);
            mode_periodic = ($urandom_range(0, 1) == 1);
            load_val      = ($urandom_range(0, 1) == 1) ? NB'($urandom_range(0, 3))
                                                        : NB'($urandom_range(0, PMAX));
            if (start && load_val == 0) ack = 0;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer_ctrl.md
Name: countdown_timer_ctrl

Overview:
Controller that sequences an Nbits synchronous down-counter as a programmable timer. It loads a start value, decrements on an external tick strobe, and supports pause, stop, one-shot and periodic (auto-reload) modes. It reports expiry with a one-cycle pulse and counts completed periods. It sits between a host/control FSM and the down-counter datapath, and is the only agent that writes the counter.

Parameters:
Nbits, 4, width of counter and load value
PW, 4, width of completed-period counter (saturating)

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  asynchronous, active-low reset (rst=0 resets immediately)
start  input  1  start request; sampled only in IDLE or DONE
stop  input  1  abort; highest priority in RUN/PAUSED
pause  input  1  level; while 1 in RUN, hold count
tick_ena  input  1  count strobe; one decrement per cycle with tick_ena=1
mode_periodic  input  1  sampled at start: 1=auto-reload, 0=one-shot
load_val  input  Nbits  start value, sampled at start
ack  input  1  clears DONE back to IDLE
count  output  Nbits  current counter value (registered)
busy  output  1  1 in RUN or PAUSED
expired  output  1  one-cycle pulse, count reached zero
zero_err  output  1  one-cycle pulse, start with load_val=0 rejected
periods  output  PW  expirations since last accepted start, saturates at 2^PW-1
state_o  output  2  IDLE=0, RUN=1, PAUSED=2, DONE=3

Behaviour:
- Reset (rst=0, async): state IDLE; count, reload register, periods, mode register=0; busy, expired, zero_err=0. All outputs are registered, so reset values appear without waiting for a clock edge.
- IDLE:
  - start=1, load_val!=0: count<=load_val, reload<=load_val, mode<=mode_periodic, periods<=0, next RUN.
  - start=1, load_val=0: zero_err=1 for one cycle, stay IDLE, count unchanged.
- RUN, priority stop > pause > tick_ena:
  - stop: count<=0, next IDLE, no expired pulse.
  - pause (no stop): next PAUSED, count held. A tick in the same cycle is ignored.
  - tick_ena with count>1: count<=count-1.
  - tick_ena with count==1: expired<=1; periods<=periods+1, saturating.
    - one-shot: count<=0, next DONE.
    - periodic: count<=reload, stay RUN.
  - No tick: hold.
- PAUSED: stop -> count<=0, IDLE. pause=0 -> RUN (decrementing resumes on the next tick after re-entry). tick_ena ignored.
- DONE: count=0, busy=0.
  - start (same rules as IDLE, including zero_err): restart directly to RUN.
  - else ack: next IDLE.
  - start and ack together: start wins.
- start in RUN/PAUSED is ignored. load_val/mode_periodic changes after start have no effect until the next accepted start.
- Counter never wraps below 0: zero is reached only via the count==1 tick path.
- expired and zero_err are high for exactly one cycle per event. In periodic mode, back-to-back expiries with reload=1 give expired=1 on every ticked cycle.
- busy = (state==RUN)|(state==PAUSED), registered together with the state.
- Latency: start accepted at edge N -> count=load_val and state RUN visible after edge N. The tick that zeroes count and the expired pulse appear on the same edge.

Test Plan:
- One-shot: load_val=3, mode=0, start 1 cycle, tick_ena=1 continuous -> count 3,2,1,0; expired=1 in the cycle count=0; state DONE, periods=1; ack -> IDLE.
- Periodic: load_val=2, mode=1, ticks continuous for 8 cycles -> count 2,1,2,1,...; expired every 2nd cycle; periods=4; state stays RUN.
- Pause: load_val=5, tick every cycle, pause=1 when count=3 for 4 cycles -> count holds 3, state PAUSED; release -> 2,1,0 with expired.
- Priority: in RUN at count=4, assert stop+pause+tick_ena in the same cycle -> next count=0, state IDLE, no expired.
- Zero load and saturation: start with load_val=0 -> zero_err pulse, stay IDLE. Periodic load_val=1, PW=4, 20 ticks -> periods saturates at 15.
- Async reset: rst=0 mid-RUN between clock edges -> count=0, state IDLE, busy=0 immediately. Release -> stays IDLE until start.
